// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the DMA priority arbiter and its
// surroundings (channel request sources, CPU hold handshake, timing-and-control).
interface dma_priority_arbiter_if #(
  parameter int NUM_CHANNELS = 8
);
  localparam int CH_W = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] dreq;
  logic [NUM_CHANNELS-1:0] sw_req;
  logic [NUM_CHANNELS-1:0] mask;
  logic                    dreq_sense;
  logic                    dack_sense;
  logic                    rotate_mode;
  logic                    hlda;
  logic                    eop;
  logic                    hrq;
  logic [NUM_CHANNELS-1:0] dack;
  logic [CH_W-1:0]         active_ch;
  logic                    grant_valid;
  logic [NUM_CHANNELS-1:0] sw_req_clr;

  // Arbiter side.
  modport slave (
    input  dreq, sw_req, mask, dreq_sense, dack_sense, rotate_mode, hlda, eop,
    output hrq, dack, active_ch, grant_valid, sw_req_clr
  );

  // Environment side: request sources, CPU and timing-and-control.
  modport master (
    output dreq, sw_req, mask, dreq_sense, dack_sense, rotate_mode, hlda, eop,
    input  hrq, dack, active_ch, grant_valid, sw_req_clr
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter: resolves hardware/software channel requests in fixed
// or rotating priority, runs the HRQ/HLDA hold handshake and drives one-hot DACK.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no grant; arbitrate whenever any channel is pending
// WAIT_HLDA | winner latched, hrq raised, waiting for the CPU to release the bus
// ACTIVE    | bus owned, dack asserted for the latched channel until eop
// RELEASE   | transfer done, hrq dropped, waiting for hlda to fall
module dma_priority_arbiter #(
  parameter int NUM_CHANNELS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dma_priority_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CHANNELS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    ACTIVE    = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t                  state, state_d;
  logic [CH_W-1:0]         active_ch_q, active_ch_d;
  logic [CH_W-1:0]         top_pri, top_pri_d;
  logic                    mode_q, mode_d;
  logic [NUM_CHANNELS-1:0] clr_q, clr_d;

  logic [NUM_CHANNELS-1:0] pend;
  logic [CH_W-1:0]         search_base;
  logic [CH_W-1:0]         winner;
  logic [CH_W-1:0]         next_ptr;
  logic [NUM_CHANNELS-1:0] sel_onehot;

  // First pending channel walking upward from base, wrapping at NUM_CHANNELS
  // (not at 2^CH_W, so non-power-of-two channel counts rotate correctly).
  function automatic logic [CH_W-1:0] pick_winner(
    input logic [NUM_CHANNELS-1:0] req,
    input logic [CH_W-1:0]         base
  );
    logic [CH_W-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = int'(base) + k;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
    return win;
  endfunction

  // Effective requests and the candidate winner for the next IDLE evaluation.
  always_comb begin
    pend        = ((bus.dreq ~^ {NUM_CHANNELS{bus.dreq_sense}}) | bus.sw_req) & ~bus.mask;
    search_base = bus.rotate_mode ? top_pri : '0;
    winner      = pick_winner(pend, search_base);
    next_ptr    = (active_ch_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : active_ch_q + 1'b1;
    sel_onehot  = NUM_CHANNELS'(1) << active_ch_q;
  end

  // Next-state logic; eop wins over a simultaneous bus revoke, hlda wins over
  // a simultaneous request withdrawal.
  always_comb begin
    state_d     = state;
    active_ch_d = active_ch_q;
    top_pri_d   = top_pri;
    mode_d      = mode_q;
    clr_d       = '0;
    case (state)
      IDLE: begin
        if (|pend) begin
          active_ch_d = winner;
          mode_d      = bus.rotate_mode;
          state_d     = WAIT_HLDA;
        end
      end
      WAIT_HLDA: begin
        if (bus.hlda)                state_d = ACTIVE;
        else if (!pend[active_ch_q]) state_d = IDLE;
      end
      ACTIVE: begin
        if (bus.eop) begin
          state_d = RELEASE;
          clr_d   = sel_onehot;
          if (mode_q) top_pri_d = next_ptr;
        end else if (!bus.hlda) begin
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (!bus.hlda) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_ch_q <= '0;
      top_pri     <= '0;
      mode_q      <= 1'b0;
      clr_q       <= '0;
    end else begin
      state       <= state_d;
      active_ch_q <= active_ch_d;
      top_pri     <= top_pri_d;
      mode_q      <= mode_d;
      clr_q       <= clr_d;
    end
  end

  // Outputs decode registered state; dack polarity follows dack_sense live.
  always_comb begin
    bus.hrq         = (state == WAIT_HLDA) || (state == ACTIVE);
    bus.grant_valid = (state == ACTIVE);
    bus.active_ch   = active_ch_q;
    bus.sw_req_clr  = clr_q;
    bus.dack        = (state == ACTIVE) ? sel_onehot : '0;
    if (!bus.dack_sense) bus.dack = ~bus.dack;
  end
endmodule
